// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, imem requests, in-flight tracking, fetch buffer (optional IF_PERF_CNT_EN counters)
module instruction_fetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);
    localparam int FA  = $clog2(FIFO_DEPTH);
    localparam int FCW = FA + 1;
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int QA  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FLUSH} state_t;

    state_t         state;
    state_t         state_next;
    logic [31:0]    fetch_pc;
    logic [31:0]    redirect_aligned;
    logic [OW-1:0]  outstanding;
    logic [OW-1:0]  outstanding_next;
    logic [OW-1:0]  drop_cnt;
    logic [OW-1:0]  drop_next;

    // PCs of requests accepted by memory, in issue order
    logic [31:0]    pcq [MAX_OUTSTANDING];
    logic [QA-1:0]  pq_wr;
    logic [QA-1:0]  pq_rd;

    // fetch buffer
    logic [31:0]    fifo_pc   [FIFO_DEPTH];
    logic [31:0]    fifo_data [FIFO_DEPTH];
    logic [FA-1:0]  f_wr;
    logic [FA-1:0]  f_rd;
    logic [FA-1:0]  head_idx;
    logic [FCW-1:0] fifo_count;
    logic [FCW-1:0] fifo_remain;
    logic [FCW-1:0] fifo_count_next;

    logic [31:0]    credit;
    logic           req_fire;
    logic           rsp_drop;
    logic           rsp_keep;
    logic           fifo_pop;

    function automatic logic [QA-1:0] qinc(input logic [QA-1:0] p);
        if (p == QA'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + QA'(1);
    endfunction

    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
    assign instr_valid      = (fifo_count != '0);

    // Request credit, response disposition, counter and FSM next-state
    always_comb begin
        credit           = 32'(fifo_count) + 32'(outstanding) - 32'(drop_cnt);
        imem_req_valid   = (state != ST_BOOT) && !redirect_valid &&
                           (32'(outstanding) < $unsigned(MAX_OUTSTANDING)) &&
                           (credit < $unsigned(FIFO_DEPTH));
        imem_req_addr    = fetch_pc;
        req_fire         = imem_req_valid && imem_req_ready;
        rsp_drop         = imem_rsp_valid && (redirect_valid || (drop_cnt != '0));
        rsp_keep         = imem_rsp_valid && !rsp_drop;
        fifo_pop         = instr_valid && !stall && !redirect_valid;
        fifo_remain      = fifo_count - FCW'(fifo_pop);
        fifo_count_next  = redirect_valid ? '0 : (fifo_remain + FCW'(rsp_keep));
        head_idx         = f_rd + FA'(fifo_pop);
        outstanding_next = outstanding + OW'(req_fire) - OW'(imem_rsp_valid);
        // on redirect every response still in flight after this edge is old-path
        if (redirect_valid) begin
            drop_next = outstanding - OW'(imem_rsp_valid);
        end else if (rsp_drop) begin
            drop_next = drop_cnt - OW'(1);
        end else begin
            drop_next = drop_cnt;
        end
        state_next = state;
        case (state)
            ST_BOOT:  state_next = ST_RUN;
            ST_RUN:   if (redirect_valid && (drop_next != '0)) state_next = ST_FLUSH;
            ST_FLUSH: if (drop_next == '0) state_next = ST_RUN;
            default:  state_next = ST_BOOT;
        endcase
    end

    // FSM, fetch PC, in-flight counters and PC-queue pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_BOOT;
            fetch_pc    <= RESET_PC & 32'hFFFF_FFFC;
            outstanding <= '0;
            drop_cnt    <= '0;
            pq_wr       <= '0;
            pq_rd       <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_aligned;
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (req_fire) begin
                pq_wr <= qinc(pq_wr);
            end
            if (imem_rsp_valid) begin
                pq_rd <= qinc(pq_rd);
            end
        end
    end

    // PC queue and fetch buffer storage
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq[pq_wr] <= fetch_pc;
        end
        if (rsp_keep) begin
            fifo_data[f_wr] <= imem_rsp_data;
            fifo_pc[f_wr]   <= pcq[pq_rd];
        end
    end

    // Buffer pointers and registered head copy; outputs hold when the buffer empties
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_wr       <= '0;
            f_rd       <= '0;
            fifo_count <= '0;
            instr_out  <= '0;
            instr_pc   <= '0;
        end else if (redirect_valid) begin
            f_wr       <= '0;
            f_rd       <= '0;
            fifo_count <= '0;
        end else begin
            fifo_count <= fifo_count_next;
            if (rsp_keep) begin
                f_wr <= f_wr + FA'(1);
            end
            if (fifo_pop) begin
                f_rd <= f_rd + FA'(1);
            end
            if (fifo_remain != '0) begin
                instr_out <= fifo_data[head_idx];
                instr_pc  <= fifo_pc[head_idx];
            end else if (rsp_keep) begin
                instr_out <= imem_rsp_data;
                instr_pc  <= pcq[pq_rd];
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] drop_inc;
    logic [32:0] drop_sum;

    // Discarded responses plus buffer entries thrown away by a redirect
    always_comb begin
        drop_inc = 32'(rsp_drop) + (redirect_valid ? 32'(fifo_count) : 32'd0);
        drop_sum = {1'b0, perf_dropped} + {1'b0, drop_inc};
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (fifo_pop && (perf_fetched != 32'hFFFF_FFFF)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            perf_dropped <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
        end
    end
`endif

endmodule
